// File: rtl/delay_feedback_mixer.sv
// delay_feedback_mixer
//
// Purpose:
//   Per-sample feedback / wet-dry mix stage that sits around a delay-line
//   circular buffer. For every accepted input it computes
//     fb_out    = SAT(floor((dry * 2^COEF_FRAC + wet * g_fb) / 2^COEF_FRAC))
//     audio_out = SAT(floor((wet * g_wet + dry * g_dry)     / 2^COEF_FRAC))
//   using a single signed multiplier that is time-shared over three states.
//   One sample is accepted at most every 5 clocks. Results appear 4 clock
//   edges after the accepting edge.
//
// Ports:
//   clk           in   1           system clock
//   rst_n         in   1           asynchronous active-low reset
//   i_in_valid    in   1           one-cycle strobe, dry/wet inputs valid
//   i_audio_dry   in   DATA_WIDTH  new input sample (signed)
//   i_audio_wet   in   DATA_WIDTH  delayed sample from the circular buffer (signed)
//   i_g_fb        in   COEF_WIDTH  feedback gain, signed Q1.COEF_FRAC
//   i_g_wet       in   COEF_WIDTH  wet mix gain, signed Q1.COEF_FRAC
//   i_g_dry       in   COEF_WIDTH  dry mix gain, signed Q1.COEF_FRAC
//   o_fb_out      out  DATA_WIDTH  sample to write back into the circular buffer
//   o_audio_out   out  DATA_WIDTH  mixed output sample
//   o_out_valid   out  1           one-cycle strobe, o_fb_out/o_audio_out updated
//   o_clip        out  1           either result saturated (valid with o_out_valid)
//   o_busy        out  1           a sample is in flight
//   o_overrun     out  1           sticky: an input arrived while busy (reset clears)

module delay_feedback_mixer #(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_audio_dry,
  input  logic [DATA_WIDTH-1:0] i_audio_wet,
  input  logic [COEF_WIDTH-1:0] i_g_fb,
  input  logic [COEF_WIDTH-1:0] i_g_wet,
  input  logic [COEF_WIDTH-1:0] i_g_dry,
  output logic [DATA_WIDTH-1:0] o_fb_out,
  output logic [DATA_WIDTH-1:0] o_audio_out,
  output logic                  o_out_valid,
  output logic                  o_clip,
  output logic                  o_busy,
  output logic                  o_overrun
);

  // Two guard bits above the full product width make the two-term sums
  // impossible to overflow, even for -1.0 * most-negative sample.
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int ACC_W  = DATA_WIDTH + COEF_WIDTH + 2;

  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]      SAT_MAX  = {{(ACC_W-DATA_WIDTH){1'b0}}, DATA_MAX};
  localparam logic signed [ACC_W-1:0]      SAT_MIN  = {{(ACC_W-DATA_WIDTH){1'b1}}, DATA_MIN};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_FB  = 3'd1,
    S_FBW = 3'd2,
    S_DRY = 3'd3,
    S_OUT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic signed [DATA_WIDTH-1:0] r_dry;
  logic signed [DATA_WIDTH-1:0] r_wet;
  logic signed [COEF_WIDTH-1:0] r_gFb;
  logic signed [COEF_WIDTH-1:0] r_gWet;
  logic signed [COEF_WIDTH-1:0] r_gDry;
  logic signed [ACC_W-1:0]      r_acc;
  logic signed [DATA_WIDTH-1:0] r_fbHold;
  logic                         r_fbClip;
  logic [DATA_WIDTH-1:0]        r_fbOut;
  logic [DATA_WIDTH-1:0]        r_audioOut;
  logic                         r_outValid;
  logic                         r_clip;
  logic                         r_overrun;

  logic                         w_capture;
  logic signed [DATA_WIDTH-1:0] w_mulA;
  logic signed [COEF_WIDTH-1:0] w_mulB;
  logic signed [PROD_W-1:0]     w_mulAExt;
  logic signed [PROD_W-1:0]     w_mulBExt;
  logic signed [PROD_W-1:0]     w_product;
  logic signed [ACC_W-1:0]      w_prodExt;
  logic signed [ACC_W-1:0]      w_dryShift;
  logic signed [ACC_W-1:0]      w_accShift;
  logic                         w_satHit;
  logic signed [DATA_WIDTH-1:0] w_satVal;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and multiplier operand selection. Each arithmetic
  // state owns the shared multiplier for exactly one product.
  always_comb begin
    w_nextState = r_state;
    w_capture   = 1'b0;
    w_mulA      = r_wet;
    w_mulB      = r_gFb;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_capture   = 1'b1;
          w_nextState = S_FB;
        end
      end
      S_FB: begin
        w_mulA      = r_wet;
        w_mulB      = r_gFb;
        w_nextState = S_FBW;
      end
      S_FBW: begin
        w_mulA      = r_wet;
        w_mulB      = r_gWet;
        w_nextState = S_DRY;
      end
      S_DRY: begin
        w_mulA      = r_dry;
        w_mulB      = r_gDry;
        w_nextState = S_OUT;
      end
      S_OUT: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operands are sign-extended to the full product width so the product
  // is exact; a DATA x COEF signed product always fits in PROD_W bits.
  assign w_mulAExt = {{COEF_WIDTH{w_mulA[DATA_WIDTH-1]}}, w_mulA};
  assign w_mulBExt = {{DATA_WIDTH{w_mulB[COEF_WIDTH-1]}}, w_mulB};
  assign w_product = w_mulAExt * w_mulBExt;
  assign w_prodExt = {{(ACC_W-PROD_W){w_product[PROD_W-1]}}, w_product};

  // Dry sample promoted to the same Q format as the products (x 1.0).
  assign w_dryShift = {{(ACC_W-DATA_WIDTH){r_dry[DATA_WIDTH-1]}}, r_dry} <<< COEF_FRAC;

  // Floor-rescale of the finished sum followed by a clamp to the sample range.
  assign w_accShift = r_acc >>> COEF_FRAC;
  assign w_satHit   = (w_accShift > SAT_MAX) || (w_accShift < SAT_MIN);

  always_comb begin
    w_satVal = w_accShift[DATA_WIDTH-1:0];
    if (w_satHit) begin
      w_satVal = w_accShift[ACC_W-1] ? DATA_MIN : DATA_MAX;
    end
  end

  // Datapath: input capture, accumulator sequencing and output registers.
  // Gains are latched only on acceptance so mid-sample gain changes cannot
  // disturb the sample in flight. Output registers hold between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dry      <= '0;
      r_wet      <= '0;
      r_gFb      <= '0;
      r_gWet     <= '0;
      r_gDry     <= '0;
      r_acc      <= '0;
      r_fbHold   <= '0;
      r_fbClip   <= 1'b0;
      r_fbOut    <= '0;
      r_audioOut <= '0;
      r_outValid <= 1'b0;
      r_clip     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (i_in_valid && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_capture) begin
        r_dry  <= i_audio_dry;
        r_wet  <= i_audio_wet;
        r_gFb  <= i_g_fb;
        r_gWet <= i_g_wet;
        r_gDry <= i_g_dry;
      end
      case (r_state)
        S_FB: begin
          r_acc <= w_dryShift + w_prodExt;
        end
        S_FBW: begin
          r_fbHold <= w_satVal;
          r_fbClip <= w_satHit;
          r_acc    <= w_prodExt;
        end
        S_DRY: begin
          r_acc <= r_acc + w_prodExt;
        end
        S_OUT: begin
          r_fbOut    <= r_fbHold;
          r_audioOut <= w_satVal;
          r_clip     <= r_fbClip | w_satHit;
          r_outValid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_fb_out    = r_fbOut;
  assign o_audio_out = r_audioOut;
  assign o_out_valid = r_outValid;
  assign o_clip      = r_clip;
  assign o_busy      = (r_state != IDLE);
  assign o_overrun   = r_overrun;

endmodule
